subtractor_core: RTL and testbench

32-bit registered two's-complement subtractor for the RISC-V structural datapath. It computes `a + ~b + c_in`, which is `a - b` when `c_in = 1`. It is built as a structural adder over the inverted subtrahend, with registered result and flags. It serves the ALU SUB path and branch-compare logic.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/subtractor_core_cla4.sv | 42 ++++
 rtl/subtractor_core.sv | 106 ++++++++++
 tb/tb_subtractor_core.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath definitions.
//   XLEN        : architectural register width
//   word_t      : one XLEN-wide datapath word
//   CLA_GRP_W   : bit width of one carry-lookahead group
//   num_groups(): number of lookahead groups needed to cover a width
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int CLA_GRP_W = 4;

  typedef logic [XLEN-1:0] word_t;

  function automatic int num_groups(input int width);
    return width / CLA_GRP_W;
  endfunction

endpackage : riscv_pkg

// File: rtl/subtractor_core_cla4.sv
// cla4: 4-bit carry-lookahead adder group.
// Ports:
//   x, y   [3:0] in  : addend bits
//   cin          in  : carry into bit 0
//   sum    [3:0] out : x + y + cin, low 4 bits
//   gg           out : group generate (carry out regardless of cin)
//   gp           out : group propagate (carry out equals cin)
//   cout         out : carry out of bit 3
// Purely combinational. Internal carries are computed by lookahead from cin
// rather than rippled bit by bit.
module cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       gp,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y;
  assign p = x ^ y;

  // Flattened lookahead equations for each bit carry.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);
  assign gp = &p;

  assign sum  = p ^ c;
  assign cout = gg | (gp & cin);

endmodule : cla4

// File: rtl/subtractor_core.sv
// subtractor_core: registered two's-complement subtractor.
// Computes {c_out, sub} = a + ~b + c_in (a - b when c_in = 1) with a chain
// of 4-bit lookahead groups, then registers the result and flags.
// Ports:
//   clk          in  : clock, rising edge
//   rst_n        in  : asynchronous active-low clear of all outputs
//   a     [W-1:0] in : minuend
//   b     [W-1:0] in : subtrahend
//   c_in         in  : carry in (1 = true subtraction, 0 = a - b - 1)
//   sub   [W-1:0] out: registered difference
//   c_out        out : registered carry (1 = no borrow)
//   ovf          out : registered signed overflow
//   zero         out : registered "difference is zero"
module subtractor_core
  import riscv_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sub,
  output logic             c_out,
  output logic             ovf,
  output logic             zero
);

  localparam int NGRP = num_groups(WIDTH);
  localparam int MSB  = WIDTH - 1;

  if ((WIDTH % CLA_GRP_W) != 0 || WIDTH < CLA_GRP_W) begin : g_width_chk
    $error("subtractor_core: WIDTH must be a positive multiple of 4");
  end

  // ---------------------------------------------------------------------
  // Structural adder over the inverted subtrahend
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] b_n;
  logic [WIDTH-1:0] d;
  logic [NGRP:0]    gc;      // group carries, gc[0] is the external carry in
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;

  assign b_n   = ~b;
  assign gc[0] = c_in;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
    cla4 u_cla4 (
      .x   (a  [gi*CLA_GRP_W +: CLA_GRP_W]),
      .y   (b_n[gi*CLA_GRP_W +: CLA_GRP_W]),
      .cin (gc[gi]),
      .sum (d  [gi*CLA_GRP_W +: CLA_GRP_W]),
      .gg  (grp_g[gi]),
      .gp  (grp_p[gi]),
      .cout(gc[gi+1])
    );
  end

  // Group generate/propagate are exported for a future second lookahead
  // level; the current chain ripples through each group's cout instead.
  logic grp_unused;
  assign grp_unused = ^{grp_g, grp_p};

  // ---------------------------------------------------------------------
  // Flags
  // ---------------------------------------------------------------------
  logic c_next;
  logic ovf_next;
  logic zero_next;

  assign c_next    = gc[NGRP];
  // Overflow only possible when operand signs differ; it shows up as the
  // result sign disagreeing with the minuend.
  assign ovf_next  = (a[MSB] != b[MSB]) && (d[MSB] != a[MSB]);
  assign zero_next = (d == '0);

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] sub_q;
  logic             c_out_q;
  logic             ovf_q;
  logic             zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      sub_q   <= d;
      c_out_q <= c_next;
      ovf_q   <= ovf_next;
      zero_q  <= zero_next;
    end
  end

  assign sub   = sub_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;
  assign zero  = zero_q;

endmodule : subtractor_core

// File: tb/tb_subtractor_core.sv
module tb_subtractor_core;
  import riscv_pkg::*;

  logic  clk;
  logic  rst_n;
  word_t a, b;
  logic  c_in;
  word_t sub;
  logic  c_out, ovf, zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    word_t a;
    word_t b;
    logic  c;
    word_t esub;
    logic  ec;
    logic  eo;
    logic  ez;
  } vec_t;

  subtractor_core #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .c_in (c_in),
    .sub  (sub),
    .c_out(c_out),
    .ovf  (ovf),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operand set on the falling edge and return just after the
  // capturing rising edge.
  task automatic drive(input word_t ta, input word_t tb_, input logic tc);
    @(negedge clk);
    a = ta; b = tb_; c_in = tc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    a = $urandom; b = $urandom; c_in = 1'b1;
    #2;
    rst_n = 1'b0;            // asserted in the low phase, no clock edge yet
    #1;
    checks++;
    if ({sub, c_out, ovf, zero} !== 35'd0) begin
      failures++;
      $display("FAIL reset_async act=%h/%b%b%b exp=0/000", sub, c_out, ovf, zero);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sub, c_out, ovf, zero} !== 35'd0) begin
      failures++;
      $display("FAIL reset_held act=%h/%b%b%b exp=0/000", sub, c_out, ovf, zero);
    end
    // Release; the very next edge captures 10 - 5.
    @(negedge clk);
    a = 32'd10; b = 32'd5; c_in = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sub !== 32'd5 || c_out !== 1'b1 || zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_release act=%h/c%b/z%b exp=00000005/c1/z0", sub, c_out, zero);
    end
  endtask

  task automatic test_basic();
    vec_t v [3] = '{
      '{32'd10,        32'd5,         1'b1, 32'h00000005, 1'b1, 1'b0, 1'b0},
      '{32'd100,       32'd100,       1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1},
      '{32'h12345678,  32'h00001000,  1'b1, 32'h12344678, 1'b1, 1'b0, 1'b0}
    };
    for (int i = 0; i < 3; i++) begin
      drive(v[i].a, v[i].b, v[i].c);
      checks++;
      if (sub !== v[i].esub || c_out !== v[i].ec || ovf !== v[i].eo || zero !== v[i].ez) begin
        failures++;
        $display("FAIL basic[%0d] act=%h c%b o%b z%b exp=%h c%b o%b z%b", i,
                 sub, c_out, ovf, zero, v[i].esub, v[i].ec, v[i].eo, v[i].ez);
      end
    end
  endtask

  task automatic test_negative();
    vec_t v [2] = '{
      '{32'd5, 32'd10, 1'b1, 32'hFFFFFFFB, 1'b0, 1'b0, 1'b0},
      '{32'd0, 32'd1,  1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 2; i++) begin
      drive(v[i].a, v[i].b, v[i].c);
      checks++;
      if (sub !== v[i].esub || c_out !== v[i].ec || ovf !== v[i].eo || zero !== v[i].ez) begin
        failures++;
        $display("FAIL negative[%0d] act=%h c%b o%b z%b exp=%h c%b o%b z%b", i,
                 sub, c_out, ovf, zero, v[i].esub, v[i].ec, v[i].eo, v[i].ez);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v [2] = '{
      '{32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0},
      '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b0, 1'b1, 1'b0}
    };
    for (int i = 0; i < 2; i++) begin
      drive(v[i].a, v[i].b, v[i].c);
      checks++;
      if (sub !== v[i].esub || c_out !== v[i].ec || ovf !== v[i].eo || zero !== v[i].ez) begin
        failures++;
        $display("FAIL overflow[%0d] act=%h c%b o%b z%b exp=%h c%b o%b z%b", i,
                 sub, c_out, ovf, zero, v[i].esub, v[i].ec, v[i].eo, v[i].ez);
      end
    end
  endtask

  task automatic test_boundaries();
    vec_t v [6] = '{
      '{32'd10,        32'd5,        1'b0, 32'h00000004, 1'b1, 1'b0, 1'b0},
      '{32'd0,         32'd0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0},
      '{32'd7,         32'd0,        1'b0, 32'h00000006, 1'b1, 1'b0, 1'b0},
      '{32'h00001234,  32'd0,        1'b1, 32'h00001234, 1'b1, 1'b0, 1'b0},
      '{32'hDEADBEEF,  32'hDEADBEEF, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1},
      '{32'h00010000,  32'd1,        1'b1, 32'h0000FFFF, 1'b1, 1'b0, 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      drive(v[i].a, v[i].b, v[i].c);
      checks++;
      if (sub !== v[i].esub || c_out !== v[i].ec || ovf !== v[i].eo || zero !== v[i].ez) begin
        failures++;
        $display("FAIL boundary[%0d] act=%h c%b o%b z%b exp=%h c%b o%b z%b", i,
                 sub, c_out, ovf, zero, v[i].esub, v[i].ec, v[i].eo, v[i].ez);
      end
    end
  endtask

  // New operands every cycle; outputs seen at each falling edge belong to
  // the operands driven one cycle earlier.
  task automatic test_back_to_back();
    word_t  pa, pb;
    logic   pc;
    longint diff;
    word_t  esub;
    logic   ec, eo, ez;
    int     shown = 0;
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (i > 0) begin
        // Unsigned view: a - b - !c is non-negative exactly when no borrow.
        diff = longint'({32'd0, pa}) - longint'({32'd0, pb}) - (pc ? 64'sd0 : 64'sd1);
        esub = diff[31:0];
        ec   = (diff >= 0);
        eo   = (pa[31] != pb[31]) && (esub[31] != pa[31]);
        ez   = (esub == 32'd0);
        checks++;
        if (sub !== esub || c_out !== ec || ovf !== eo || zero !== ez) begin
          failures++;
          if (shown < 10) begin
            shown++;
            $display("FAIL b2b[%0d] a=%h b=%h c=%b act=%h c%b o%b z%b exp=%h c%b o%b z%b",
                     i, pa, pb, pc, sub, c_out, ovf, zero, esub, ec, eo, ez);
          end
        end
      end
      if (i < 1000) begin
        case (i % 8)
          0:       begin pa = $urandom; pb = pa;  end
          1:       begin pa = $urandom; pb = 32'd0; end
          default: begin pa = $urandom; pb = $urandom; end
        endcase
        pc = (i % 5 == 3) ? 1'b0 : 1'b1;
        a = pa; b = pb; c_in = pc;
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(32'd10, 32'd5, 1'b1);
    @(negedge clk);
    a = 32'd200; b = 32'd50; c_in = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sub, c_out, ovf, zero} !== 35'd0) begin
      failures++;
      $display("FAIL reset_midstream act=%h/%b%b%b exp=0/000", sub, c_out, ovf, zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sub !== 32'd150 || c_out !== 1'b1 || zero !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_midstream_release act=%h c%b o%b z%b exp=00000096 c1 o0 z0",
               sub, c_out, ovf, zero);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overflow();
    test_boundaries();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_subtractor_core
